// File: rtl/gba_timer_bank.sv
// Bank of GBA-style up-counting timers with reload, prescaler and cascade, behind a byte-addressed window.
// Define TIMER_IRQ_EN to add the registered per-timer interrupt pulse gated by control bit 6.

module gba_timer_bank #(
  parameter int          NUM_TIMERS = 4,
  parameter int          CNT_WIDTH  = 16,
  parameter int          TICK_DIV   = 3,
  parameter logic [11:0] BASE_ADDR  = 12'h100
) (
  input  logic                  clk_mem,
  input  logic                  rst_n,
  input  logic [23:0]           addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  input  logic                  read,
  input  logic                  write,
  input  logic [1:0]            width,
  output logic [NUM_TIMERS-1:0] ovf,
  output logic [NUM_TIMERS-1:0] irq
);

  localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [12:0]      WIN_BYTES = 13'(4 * NUM_TIMERS);
`ifdef TIMER_IRQ_EN
  localparam logic [7:0]       CTRL_MASK = 8'hC7;
`else
  localparam logic [7:0]       CTRL_MASK = 8'h87;
`endif

  logic [DIV_W-1:0]      div_q;
  logic                  tick;

  logic [CNT_WIDTH-1:0]  cnt_q      [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  reload_q   [NUM_TIMERS];
  logic [7:0]            ctrl_q     [NUM_TIMERS];
  logic [9:0]            presc_q    [NUM_TIMERS];

  logic [CNT_WIDTH-1:0]  reload_eff [NUM_TIMERS];
  logic [7:0]            ctrl_eff   [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  cnt_nxt    [NUM_TIMERS];
  logic [9:0]            presc_nxt  [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] ovf_c;

  logic [11:0]           offset;
  logic                  hit;
  logic [2:0]            sel;
  logic [4:0]            shift;
  logic [31:0]           wmask;
  logic [31:0]           wdata;
  logic [31:0]           rd_word;
  logic                  unused_bits;

  // The read strobe and the upper address bits carry no meaning for this block.
  assign unused_bits = ^{read, addr[23:12]};

  assign offset = addr[11:0] - BASE_ADDR;
  assign hit    = (addr[11:0] >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign sel    = offset[4:2];
  assign shift  = {addr[1:0], 3'b000};

  always_comb begin
    case (width)
      2'd0:    wmask = 32'h0000_00FF << shift;
      2'd1:    wmask = 32'h0000_FFFF << shift;
      default: wmask = 32'hFFFF_FFFF << shift;
    endcase
    wdata = data_in << shift;
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // A write lands in the same cycle it is sampled, so every decision below uses the
  // post-write control/reload view; carry ripples timer 0 -> N-1 to resolve cascades in one cycle.
  always_comb begin : timer_next
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic        wr;
    logic        en_rise;
    logic        casc;
    logic        presc_hit;
    logic        inc;
    logic        wrap;
    logic        carry;
    logic [9:0]  presc_last;

    cur_word   = '0;
    merged     = '0;
    wr         = 1'b0;
    en_rise    = 1'b0;
    casc       = 1'b0;
    presc_hit  = 1'b0;
    inc        = 1'b0;
    wrap       = 1'b0;
    carry      = 1'b0;
    presc_last = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cur_word      = {8'h00, ctrl_q[i], 16'(reload_q[i])};
      merged        = (cur_word & ~wmask) | (wdata & wmask);
      wr            = write && hit && (sel == 3'(i));
      ctrl_eff[i]   = wr ? (merged[23:16] & CTRL_MASK) : ctrl_q[i];
      reload_eff[i] = wr ? merged[CNT_WIDTH-1:0] : reload_q[i];
      en_rise       = !ctrl_q[i][7] && ctrl_eff[i][7];

      case (ctrl_eff[i][1:0])
        2'd0:    presc_last = 10'd0;
        2'd1:    presc_last = 10'd63;
        2'd2:    presc_last = 10'd255;
        default: presc_last = 10'd1023;
      endcase

      casc      = (i > 0) && ctrl_eff[i][2];
      presc_hit = tick && (presc_q[i] >= presc_last);
      inc       = ctrl_eff[i][7] && !en_rise && (casc ? carry : presc_hit);
      wrap      = inc && (cnt_q[i] == '1);
      ovf_c[i]  = wrap;
      carry     = wrap;

      cnt_nxt[i]   = cnt_q[i];
      presc_nxt[i] = presc_q[i];
      if (en_rise) begin
        cnt_nxt[i]   = reload_eff[i];
        presc_nxt[i] = '0;
      end else if (ctrl_eff[i][7]) begin
        if (inc) begin
          cnt_nxt[i] = wrap ? reload_eff[i] : cnt_q[i] + 1'b1;
        end
        if (!casc && tick) begin
          presc_nxt[i] = presc_hit ? 10'd0 : presc_q[i] + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
        ctrl_q[i]   <= '0;
        presc_q[i]  <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        cnt_q[i]    <= cnt_nxt[i];
        reload_q[i] <= reload_eff[i];
        ctrl_q[i]   <= ctrl_eff[i];
        presc_q[i]  <= presc_nxt[i];
      end
      ovf <= ovf_c;
    end
  end

`ifdef TIMER_IRQ_EN
  logic [NUM_TIMERS-1:0] irq_c;

  always_comb begin
    irq_c = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      irq_c[i] = ovf_c[i] && ctrl_eff[i][6];
    end
  end

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      irq <= '0;
    end else begin
      irq <= irq_c;
    end
  end
`else
  assign irq = '0;
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (hit && (sel == 3'(i))) begin
        rd_word = {8'h00, ctrl_q[i], 16'(cnt_q[i])};
      end
    end
  end

  assign data_out = rd_word >> shift;

endmodule
